spi_frame_slave: RTL
====================

Name: spi_frame_slave

Overview:
- SPI mode-0 responder for the fixed 5-byte frame protocol used by the board's SPI master controller.
- Oversamples sclk/cs_n/mosi in the system clock domain. Assembles one received frame, shifts out a preloaded response frame on miso, and reports frame completion or framing error.
- Sits at the peripheral end of the link (FPGA-emulated device or loopback test target).

Parameters:
- FRAME_BYTES, 5, bytes per frame (cs_n low period).
- SYNC_STAGES, 2, synchronizer flops on each SPI input (min 2).

Ports:
- clk  in  1  system clock, posedge; must be ≥ 8× sclk frequency.
- rst  in  1  reset: synchronous, active-high.
- sclk  in  1  SPI clock from master, idle low (mode 0).
- cs_n  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- tx_frame  in  8*FRAME_BYTES  response frame; bit [MSB] is sent first.
- rx_frame  out  8*FRAME_BYTES  last good received frame; first received bit lands in [MSB].
- rx_valid  out  1  one-clk pulse: complete frame captured.
- rx_err  out  1  one-clk pulse: frame aborted or overrun.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset values: miso=0, rx_frame=0, rx_valid=0, rx_err=0, busy=0, state=IDLE, counters=0.
- Input handling:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - One further flop on sclk and cs_n provides edge detection.
  - All decisions use the synchronized signals.
- States: IDLE, SHIFT, ARM.
- ARM is entered after reset. It waits for synchronized cs_n=1, then goes to IDLE. A frame already in progress at reset release is therefore ignored.
- IDLE:
  - On cs_n fall: load tx_sr←tx_frame, clear bit_cnt and byte_cnt, set miso←tx_frame[MSB], go to SHIFT.
  - tx_frame is sampled only at this point; later changes do not affect the current frame.
- SHIFT, on sclk rise:
  - rx_sr←{rx_sr, mosi}.
  - bit_cnt increments modulo 8; byte_cnt increments when bit_cnt wraps 7→0.
- SHIFT, on sclk fall:
  - tx_sr shifts left with 0 fill; miso←new tx_sr[MSB].
  - After FRAME_BYTES bytes, miso=0.
- SHIFT, overrun:
  - A sclk rise when byte_cnt==FRAME_BYTES sets an internal overrun flag.
  - Further bits are not shifted into rx_sr.
- SHIFT, on cs_n rise:
  - Good frame (byte_cnt==FRAME_BYTES, bit_cnt==0, no overrun): rx_frame←rx_sr and rx_valid=1 for one clk.
  - Any other case: rx_err=1 for one clk and rx_frame keeps its old value.
  - Then go to IDLE.
- Same-cycle events: cs_n rise together with sclk rise: process the cs_n rise only; the sclk edge is discarded.
- Latency:
  - rx_valid/rx_err: SYNC_STAGES+2 clk after the cs_n pin rises.
  - First miso bit: valid SYNC_STAGES+2 clk after the cs_n pin falls. The master must allow this setup before the first sclk rise.
- miso when deselected: 0 whenever state≠SHIFT.
- busy=1 exactly while in SHIFT.
- Reset asserted mid-frame: behaves as a full reset. No pulse is issued, and the block then passes through ARM.

Optional Feature:
- Macro: SPI_FRAME_SLAVE_MISO_TRISTATE_EN.
- Defined: miso=1'bz whenever state≠SHIFT, so multiple slaves can share the line.
- Undefined: miso driven 0 when not in SHIFT, as above.
- All other behaviour is identical.

Decomposition:
- Shared package spi_pkg holds:
  - state enum {ST_ARM, ST_IDLE, ST_SHIFT};
  - localparam SPI_FRAME_BYTES=5;
  - function frame_width(bytes)=8*bytes.
- Sub-module spi_sync_edge (WIDTH=1, STAGES) outputs the synchronized level plus rise and fall pulses.
  - Instantiated for sclk and cs_n.
  - mosi uses the level output only.

Test Plan:
- Good frame: tx_frame=40'hA1B2C3D4E5; master sends 40'h123456789A (sclk=clk/16) -> rx_frame=40'h123456789A; single rx_valid pulse; miso bit stream = A1B2C3D4E5 MSB-first.
- Short frame: cs_n rises after 20 bits -> rx_err pulse; rx_frame unchanged; no rx_valid.
- Overrun: 41 sclk pulses -> miso=0 on bit 41; rx_err pulse; rx_frame unchanged.
- Reset mid-frame: rst high after 12 bits, with cs_n held low after rst release and 28 more bits sent -> no pulses. Next full frame 40'hFFFFFFFFFF -> rx_valid pulse, rx_frame=40'hFFFFFFFFFF.
- Back-to-back: two frames with 4-clk cs_n high gap, tx_frame changed in between -> two rx_valid pulses; each response equals the tx_frame value at its cs_n fall.
- Tristate build: with SPI_FRAME_SLAVE_MISO_TRISTATE_EN defined -> miso=z in IDLE and ARM, driven during SHIFT.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding, frame size and width helper for the SPI frame slave.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  localparam int SPI_FRAME_BYTES = 5;

  function automatic int frame_width(input int bytes);
    return 8 * bytes;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses derived from the
// synchronized level and one extra history flop.
module spi_sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             prev_q, prev_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 fixed-frame responder, oversampled in the clk domain.
// Build option SPI_FRAME_SLAVE_MISO_TRISTATE_EN: miso floats (z) outside SHIFT.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int FRAME_BYTES = SPI_FRAME_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sclk,
  input  logic                                cs_n,
  input  logic                                mosi,
  output logic                                miso,
  input  logic [frame_width(FRAME_BYTES)-1:0] tx_frame,
  output logic [frame_width(FRAME_BYTES)-1:0] rx_frame,
  output logic                                rx_valid,
  output logic                                rx_err,
  output logic                                busy
);

  localparam int              FW        = frame_width(FRAME_BYTES);
  localparam int              BCW       = $clog2(FRAME_BYTES + 1);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(FRAME_BYTES);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_state_e      state_q, state_d;
  logic [FW-1:0]   tx_sr_q, tx_sr_d;
  logic [FW-1:0]   rx_sr_q, rx_sr_d;
  logic [FW-1:0]   rx_frame_q, rx_frame_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic            overrun_q, overrun_d;
  logic            miso_q, miso_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q, rx_err_d;

  spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = sclk_lvl ^ mosi_rise ^ mosi_fall;

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_frame_d = rx_frame_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    overrun_d  = overrun_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    case (state_q)
      // Wait out any frame that was already running when reset released.
      ST_ARM: begin
        miso_d = 1'b0;
        if (cs_lvl) state_d = ST_IDLE;
        else        state_d = ST_ARM;
      end
      ST_IDLE: begin
        if (cs_fall) begin
          tx_sr_d    = tx_frame;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          overrun_d  = 1'b0;
          miso_d     = tx_frame[FW-1];
          state_d    = ST_SHIFT;
        end else begin
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Deselect wins over a coincident sclk rise; that edge is dropped.
        if (cs_rise) begin
          if (byte_cnt_q == LAST_BYTE && bit_cnt_q == 3'd0 && !overrun_q) begin
            rx_frame_d = rx_sr_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          if (byte_cnt_q == LAST_BYTE) begin
            overrun_d = 1'b1;
          end else begin
            rx_sr_d   = {rx_sr_q[FW-2:0], mosi_lvl};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_cnt_d = byte_cnt_q + BCW'(1);
            else                   byte_cnt_d = byte_cnt_q;
          end
        end else if (sclk_fall) begin
          tx_sr_d = {tx_sr_q[FW-2:0], 1'b0};
          miso_d  = tx_sr_q[FW-2];
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        miso_d  = 1'b0;
        state_d = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARM;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_frame_q <= '0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      overrun_q  <= 1'b0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_frame_q <= rx_frame_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      overrun_q  <= overrun_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign rx_frame = rx_frame_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

`ifdef SPI_FRAME_SLAVE_MISO_TRISTATE_EN
  assign miso = busy ? miso_q : 1'bz;
`else
  assign miso = miso_q;
`endif

endmodule
